// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// Lets the fetch requester and the data requester share one SRAM-like bus,
// one transaction at a time. Data wins ties unless fetch has already waited
// through MAX_DATA_STREAK back-to-back data grants.
//
// Handshake (identical on both requester ports and on the bus side):
//   req      : the requester holds req and its request fields stable until it
//              sees addr_ok in the same cycle.
//   addr_ok  : the request was accepted in this cycle. Once accepted, the
//              requester may change or drop its inputs freely.
//   data_ok  : a one-cycle pulse that completes the accepted request. rdata is
//              meaningful only while data_ok is high. Writes also get data_ok.
module sram_bus_arbiter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_addr,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,

  output logic        arb_busy,
  output logic [1:0]  dbg_state,
  output logic [$clog2(MAX_DATA_STREAK+1)-1:0] dbg_streak
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  // IDLE: arbitrate. REQ: present the latched request to the bus.
  // RESP: wait for the bus response and steer it to the owner.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Owner encoding: 0 = fetch side, 1 = data side.
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  state_t        state_q;
  state_t        state_d;
  logic          owner_q;
  logic [SW-1:0] streak_q;

  logic          lat_wr_q;
  logic [1:0]    lat_size_q;
  logic [31:0]   lat_addr_q;
  logic [3:0]    lat_wstrb_q;
  logic [31:0]   lat_wdata_q;

  logic          grant_data;
  logic          grant_inst;
  logic          resp_done;

  // Grant, handshake and completion decode; reset masks every strobe.
  always_comb begin
    grant_data   = 1'b0;
    grant_inst   = 1'b0;
    resp_done    = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    sram_req     = 1'b0;

    if (!reset) begin
      if (state_q == IDLE) begin
        // Data goes first unless fetch has been passed over too many times.
        grant_data = data_req && !(inst_req && (streak_q == STREAK_MAX));
        grant_inst = inst_req && !grant_data;
      end
      inst_addr_ok = grant_inst;
      data_addr_ok = grant_data;

      sram_req = (state_q == REQ);

      // A response outside RESP has no transaction to belong to.
      resp_done    = (state_q == RESP) && sram_data_ok;
      inst_data_ok = resp_done && (owner_q == OWNER_INST);
      data_data_ok = resp_done && (owner_q == OWNER_DATA);
    end
  end

  // Next-state logic for the three-phase transaction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_data || grant_inst) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (sram_addr_ok) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // Returning to IDLE here means the next grant is one cycle later.
        if (sram_data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winner's request so the bus never sees live inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWNER_INST;
      lat_wr_q    <= 1'b0;
      lat_size_q  <= 2'd0;
      lat_addr_q  <= 32'd0;
      lat_wstrb_q <= 4'd0;
      lat_wdata_q <= 32'd0;
    end else if (grant_data) begin
      owner_q     <= OWNER_DATA;
      lat_wr_q    <= data_wr;
      lat_size_q  <= data_size;
      lat_addr_q  <= data_addr;
      lat_wstrb_q <= data_wstrb;
      lat_wdata_q <= data_wdata;
    end else if (grant_inst) begin
      owner_q     <= OWNER_INST;
      lat_wr_q    <= inst_wr;
      lat_size_q  <= inst_size;
      lat_addr_q  <= inst_addr;
      lat_wstrb_q <= inst_wstrb;
      lat_wdata_q <= inst_wdata;
    end
  end

  // Count data grants that bypassed a waiting fetch; any other grant clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= '0;
    end else if (grant_data) begin
      if (!inst_req) begin
        streak_q <= '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_q <= streak_q + STREAK_ONE;
      end
    end else if (grant_inst) begin
      streak_q <= '0;
    end
  end

  assign sram_wr    = lat_wr_q;
  assign sram_size  = lat_size_q;
  assign sram_addr  = lat_addr_q;
  assign sram_wstrb = lat_wstrb_q;
  assign sram_wdata = lat_wdata_q;

  // Read data is shared; only the owner's data_ok makes it meaningful.
  assign inst_rdata = sram_rdata;
  assign data_rdata = sram_rdata;

  assign arb_busy   = (state_q != IDLE);
  assign dbg_state  = state_q;
  assign dbg_streak = streak_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios with literal expectations,
// then random traffic, all shadowed by a transaction-level model.
module tb_sram_bus_arbiter;

  localparam int MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'd0;
  logic [31:0] inst_addr = 32'd0, inst_wdata = 32'd0;
  logic [3:0]  inst_wstrb = 4'd0;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
  logic [3:0]  data_wstrb = 4'd0;
  logic        sram_addr_ok = 1'b0, sram_data_ok = 1'b0;
  logic [31:0] sram_rdata = 32'd0;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata;
  logic [3:0]  sram_wstrb;
  logic        arb_busy;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_streak;

  sram_bus_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
    .sram_addr(sram_addr), .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .arb_busy(arb_busy), .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding transaction: open = granted and not yet answered,
  // accepted = the bus has taken the address.
  bit          m_open = 1'b0, m_acc = 1'b0, m_owner_data = 1'b0;
  int          m_streak = 0;
  int          n_done = 0;
  logic        m_wr = 1'b0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
  logic [3:0]  m_wstrb = 4'd0;

  function automatic bit f_gd();
    return !m_open && data_req && !(inst_req && m_streak == MAX);
  endfunction

  function automatic bit f_gi();
    return !m_open && inst_req && !f_gd();
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_open = 1'b0; m_acc = 1'b0; m_owner_data = 1'b0; m_streak = 0;
      m_wr = 1'b0; m_size = 2'd0; m_addr = 32'd0; m_wstrb = 4'd0; m_wdata = 32'd0;
    end else if (!m_open) begin
      if (f_gd()) begin
        m_open = 1'b1; m_acc = 1'b0; m_owner_data = 1'b1;
        m_wr = data_wr; m_size = data_size; m_addr = data_addr;
        m_wstrb = data_wstrb; m_wdata = data_wdata;
        m_streak = inst_req ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
      end else if (f_gi()) begin
        m_open = 1'b1; m_acc = 1'b0; m_owner_data = 1'b0;
        m_wr = inst_wr; m_size = inst_size; m_addr = inst_addr;
        m_wstrb = inst_wstrb; m_wdata = inst_wdata;
        m_streak = 0;
      end
    end else if (!m_acc) begin
      if (sram_addr_ok) m_acc = 1'b1;
    end else if (sram_data_ok) begin
      m_open = 1'b0; m_acc = 1'b0; n_done++;
    end
  end

  // Compare every output against the model, mid-cycle.
  always @(negedge clk) begin
    bit resp;
    resp = m_open && m_acc && sram_data_ok && !reset;
    if (reset) begin
      chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
      chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
      chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
      chk("rst_sram_req", 32'(sram_req), 32'd0);
      chk("rst_arb_busy", 32'(arb_busy), 32'd0);
      chk("rst_streak", 32'(dbg_streak), 32'd0);
      chk("rst_sram_addr", sram_addr, 32'd0);
    end else begin
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(f_gi()));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(f_gd()));
      chk("sram_req", 32'(sram_req), 32'(m_open && !m_acc));
      chk("arb_busy", 32'(arb_busy), 32'(m_open));
      chk("inst_data_ok", 32'(inst_data_ok), 32'(resp && !m_owner_data));
      chk("data_data_ok", 32'(data_data_ok), 32'(resp && m_owner_data));
      chk("sram_wr", 32'(sram_wr), 32'(m_wr));
      chk("sram_size", 32'(sram_size), 32'(m_size));
      chk("sram_addr", sram_addr, m_addr);
      chk("sram_wstrb", 32'(sram_wstrb), 32'(m_wstrb));
      chk("sram_wdata", sram_wdata, m_wdata);
      chk("streak", 32'(dbg_streak), 32'(m_streak));
    end
    chk("inst_rdata", inst_rdata, sram_rdata);
    chk("data_rdata", data_rdata, sram_rdata);
  end

  // ---------------- driver tasks ----------------
  // Step to just after the next rising edge; bus strobes default low.
  task automatic cyc();
    @(posedge clk);
    #1;
    sram_addr_ok = 1'b0;
    sram_data_ok = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // From a grant edge: bus accepts at once, answers the next cycle.
  task automatic finish_txn(input bit drop_reqs);
    cyc();
    if (drop_reqs) begin
      inst_req = 1'b0;
      data_req = 1'b0;
    end
    sram_addr_ok = 1'b1;
    sample();
    cyc();
    sram_data_ok = 1'b1;
    sram_rdata = $urandom;
    sample();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    string grants;
    int exp_streak[10];
    logic [7:0] got, exp;
    bit i_acc, d_acc;
    int done_before;

    grants = "DDDDIDDDDI";
    exp_streak = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

    // Reset with both requests up: no strobe may leak out.
    inst_req = 1'b1;
    data_req = 1'b1;
    sample();
    sample();
    inst_req = 1'b0;
    data_req = 1'b0;
    #2 reset = 1'b0;

    // Single data load.
    cyc();
    data_req = 1'b1; data_addr = 32'h1000_0004; data_size = 2'd2; data_wr = 1'b0;
    sample();
    chk("t1_data_addr_ok", 32'(data_addr_ok), 32'd1);
    cyc();
    data_req = 1'b0;
    sram_addr_ok = 1'b1;
    sample();
    chk("t1_sram_req", 32'(sram_req), 32'd1);
    chk("t1_sram_addr", sram_addr, 32'h1000_0004);
    cyc();
    sram_data_ok = 1'b1;
    sram_rdata = 32'hDEAD_BEEF;
    sample();
    chk("t1_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("t1_data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("t1_inst_data_ok", 32'(inst_data_ok), 32'd0);

    // Simultaneous requests: data first, fetch on the following IDLE.
    cyc();
    chk("t2_idle", 32'(arb_busy), 32'd0);
    inst_req = 1'b1; inst_addr = 32'h0000_0100; inst_size = 2'd2;
    data_req = 1'b1; data_addr = 32'h1000_0020;
    sample();
    chk("t2_data_first", 32'(data_addr_ok), 32'd1);
    chk("t2_inst_waits", 32'(inst_addr_ok), 32'd0);
    cyc();
    data_req = 1'b0;
    sram_addr_ok = 1'b1;
    sample();
    chk("t2_inst_no_ok_in_req", 32'(inst_addr_ok), 32'd0);
    cyc();
    sram_data_ok = 1'b1;
    sample();
    chk("t2_data_done", 32'(data_data_ok), 32'd1);
    cyc();
    sample();
    chk("t2_inst_granted", 32'(inst_addr_ok), 32'd1);
    finish_txn(1'b1);
    chk("t2_inst_done", 32'(inst_data_ok), 32'd1);

    // Fairness under continuous contention.
    for (int i = 0; i < 10; i++) exp_q.push_back(grants[i]);
    for (int k = 0; k < 10; k++) begin
      cyc();
      inst_req = 1'b1;
      data_req = 1'b1;
      sample();
      chk("t3_streak_before", 32'(dbg_streak), 32'(exp_streak[k]));
      got = data_addr_ok ? 8'h44 : (inst_addr_ok ? 8'h49 : 8'h2D);
      exp = exp_q.pop_front();
      chk("t3_grant_order", 32'(got), 32'(exp));
      finish_txn(k == 9);
    end

    // Bus backpressure: latched address survives input changes.
    cyc();
    data_req = 1'b1; data_addr = 32'h3000_0008; data_size = 2'd2;
    sample();
    chk("t4_grant", 32'(data_addr_ok), 32'd1);
    cyc();
    data_req = 1'b0;
    data_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("t4_sram_req_held", 32'(sram_req), 32'd1);
      chk("t4_sram_addr_held", sram_addr, 32'h3000_0008);
      cyc();
    end
    sram_addr_ok = 1'b1;
    sample();
    chk("t4_last_req", 32'(sram_req), 32'd1);
    cyc();
    sample();
    chk("t4_resp_sram_req", 32'(sram_req), 32'd0);
    chk("t4_resp_busy", 32'(arb_busy), 32'd1);
    cyc();
    sram_data_ok = 1'b1;
    sample();
    chk("t4_data_ok", 32'(data_data_ok), 32'd1);

    // Store.
    cyc();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_wdata = 32'h0000_ABCD; data_addr = 32'h2000_0002; data_size = 2'd1;
    sample();
    chk("t5_grant", 32'(data_addr_ok), 32'd1);
    cyc();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0; data_wdata = 32'd0;
    sram_addr_ok = 1'b1;
    sample();
    chk("t5_sram_wr", 32'(sram_wr), 32'd1);
    chk("t5_sram_wstrb", 32'(sram_wstrb), 32'b0011);
    chk("t5_sram_wdata", sram_wdata, 32'h0000_ABCD);
    cyc();
    sram_data_ok = 1'b1;
    sample();
    chk("t5_data_ok", 32'(data_data_ok), 32'd1);

    // Reset while in RESP.
    cyc();
    data_req = 1'b1; data_addr = 32'h0000_0040; data_size = 2'd2;
    sample();
    cyc();
    data_req = 1'b0;
    sram_addr_ok = 1'b1;
    sample();
    cyc();
    sample();
    chk("t6_in_resp", 32'(arb_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy_drop", 32'(arb_busy), 32'd0);
    chk("t6_sram_req_drop", 32'(sram_req), 32'd0);
    sample();
    #2 reset = 1'b0;
    cyc();
    sram_data_ok = 1'b1;
    sample();
    chk("t6_no_data_ok", 32'(data_data_ok), 32'd0);
    chk("t6_no_inst_data_ok", 32'(inst_data_ok), 32'd0);
    cyc();
    data_req = 1'b1; data_addr = 32'h0000_0050;
    sample();
    chk("t6_regrant", 32'(data_addr_ok), 32'd1);
    finish_txn(1'b1);
    chk("t6_regrant_done", 32'(data_data_ok), 32'd1);

    // Random traffic; requesters hold their request until accepted.
    i_acc = 1'b0;
    d_acc = 1'b0;
    done_before = n_done;
    for (int c = 0; c < 2000; c++) begin
      cyc();
      if (!inst_req || i_acc) begin
        inst_req = ($urandom_range(0, 2) == 0);
        inst_wr = ($urandom_range(0, 7) == 0);
        inst_size = 2'($urandom_range(0, 2));
        inst_addr = $urandom;
        inst_wstrb = 4'($urandom);
        inst_wdata = $urandom;
      end
      if (!data_req || d_acc) begin
        data_req = ($urandom_range(0, 1) == 0);
        data_wr = ($urandom_range(0, 1) == 0);
        data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom;
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
      end
      sram_addr_ok = ($urandom_range(0, 2) != 0);
      sram_data_ok = ($urandom_range(0, 2) != 0);
      sram_rdata = $urandom;
      sample();
      i_acc = inst_addr_ok;
      d_acc = data_addr_ok;
    end
    cyc();
    inst_req = 1'b0;
    data_req = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    sample();
    chk("rand_progress", 32'(n_done > done_before + 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares the single SRAM-like memory bus between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM stages).
- Each requester uses a req/addr_ok/data_ok split handshake. The block grants one requester at a time and registers its request. It drives the request onto the shared bus until the address is accepted, then routes the response back to the owner.
- Data has priority, with a bounded-streak fairness rule so fetch cannot starve.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while inst_req is pending before inst is forced; range 1..7.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
inst_req  in  1  fetch request valid
inst_wr  in  1  fetch write flag (normally 0; passed through)
inst_size  in  2  0=byte, 1=half, 2=word
inst_addr  in  32  fetch address
inst_wstrb  in  4  byte write strobes
inst_wdata  in  32  write data
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid this cycle
inst_rdata  out  32  fetch read data
data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  data-side request, same meaning as the inst_* inputs
data_addr_ok, data_data_ok  out  1/1  data-side handshake
data_rdata  out  32  data read data
sram_req  out  1  shared bus request
sram_wr  out  1  shared bus write flag
sram_size  out  2  shared bus size
sram_addr  out  32  shared bus address
sram_wstrb  out  4  shared bus strobes
sram_wdata  out  32  shared bus write data
sram_addr_ok  in  1  bus accepted request
sram_data_ok  in  1  bus response valid
sram_rdata  in  32  bus read data
arb_busy  out  1  state != IDLE

Behaviour:
- Reset is async and active-high. The following apply immediately and remain while reset is high:
  - state=IDLE, owner=0 (inst), streak=0, all latched request registers=0.
  - All addr_ok/data_ok outputs=0; sram_req=0; arb_busy=0.
- A reset mid-transaction abandons it. No data_ok is issued for it.
- States:
  - IDLE:
    - Grant decision is combinational.
    - grant_data = data_req && !(inst_req && streak==MAX_DATA_STREAK).
    - grant_inst = inst_req && !grant_data.
    - The granted side's addr_ok=1 in this same cycle. The losing side's addr_ok=0 and it must hold its request.
    - On a grant, at the clock edge: latch wr/size/addr/wstrb/wdata of the granted side, set owner, go to REQ.
    - With no request, stay in IDLE.
  - REQ:
    - sram_req=1; sram_* are driven from the latched registers only, never from live inputs.
    - If sram_addr_ok=1, go to RESP at the edge; otherwise stay in REQ with the request held stable.
  - RESP:
    - sram_req=0.
    - When sram_data_ok=1, the owner's data_ok=1 in the same cycle (combinational pass-through), then go to IDLE.
    - The non-owner's data_ok is never asserted.
    - A sram_data_ok seen in IDLE or REQ is ignored.
- inst_rdata and data_rdata are both wired to sram_rdata permanently. They are qualified only by the respective data_ok.
- No new grant is made in the cycle data_ok is returned; arbitration resumes in IDLE.
- Minimum transaction length: 3 cycles (IDLE grant, REQ with immediate addr_ok, RESP with immediate data_ok).
- Only one transaction is outstanding at a time.
- Streak counter, width clog2(MAX_DATA_STREAK+1), updated only on a grant edge:
  - data grant with inst_req=1: streak+1, saturating at MAX_DATA_STREAK.
  - data grant with inst_req=0: streak=0.
  - inst grant: streak=0.
- Writes complete like reads: data_ok is returned for writes too, with rdata don't-care.
- sram_* outputs other than sram_req hold their latched values in IDLE/RESP (no toggling requirement beyond that).

Test Plan:
1. Single data load:
   - Stimulus: data_req=1, addr=0x1000_0004, size=2. Bus gives addr_ok on the 1st REQ cycle and data_ok one cycle later with rdata=0xDEADBEEF.
   - Required response: data_addr_ok in cycle 0; sram_req cycle 1 with addr 0x1000_0004; data_data_ok=1 and data_rdata=0xDEADBEEF in cycle 2; inst_data_ok stays 0.
2. Simultaneous requests:
   - Stimulus: inst_req and data_req both high in IDLE, streak=0.
   - Required response: data granted first (data_addr_ok=1, inst_addr_ok=0). After data completes, inst is granted on the next IDLE cycle.
3. Fairness:
   - Stimulus: inst_req and data_req held high continuously with MAX_DATA_STREAK=4.
   - Required response: grant order is D,D,D,D,I,D,D,D,D,I. streak reads 4 before each inst grant and 0 after it.
4. Bus backpressure:
   - Stimulus: sram_addr_ok held 0 for 5 cycles while the requester changes data_addr to 0x0.
   - Required response: sram_req stays 1 and sram_addr stays at the latched original value. RESP is entered one edge after addr_ok.
5. Store:
   - Stimulus: data_wr=1, wstrb=4'b0011, wdata=0x0000_ABCD, addr=0x2000_0002.
   - Required response: sram_wr=1, sram_wstrb=0011, sram_wdata=0x0000_ABCD in REQ; data_data_ok pulse on sram_data_ok.
6. Reset mid-RESP:
   - Stimulus: assert reset asynchronously between edges while in RESP.
   - Required response: arb_busy and sram_req drop immediately. A later sram_data_ok produces no data_ok, and the next request is granted normally.
